// File: rtl/fft_result_serializer.sv
// rtl/fft_result_serializer.sv - beat FIFO replaying 8 complex results per beat as a sample stream (optional saturation: FFT_RESULT_SER_SAT_EN)
module fft_result_serializer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 24,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [3:0][IN_WIDTH-1:0]       in_col1_r,
  input  logic [3:0][IN_WIDTH-1:0]       in_col1_i,
  input  logic [3:0][IN_WIDTH-1:0]       in_col2_r,
  input  logic [3:0][IN_WIDTH-1:0]       in_col2_i,
  input  logic [10:0]                    in_idx_col1,
  input  logic [10:0]                    in_idx_col2,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_WIDTH-1:0]           out_r,
  output logic [OUT_WIDTH-1:0]           out_i,
  output logic [12:0]                    out_addr,
  output logic                           out_last,
  output logic                           almost_full,
  output logic [$clog2(DEPTH):0]         level,
  output logic                           overflow,
  input  logic                           ovf_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam int AF_TH_I = (DEPTH > AF_MARGIN) ? (DEPTH - AF_MARGIN) : 0;
  localparam logic [LW-1:0] AF_TH = LW'(AF_TH_I);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  logic [3:0][IN_WIDTH-1:0] r_mem_c1r [DEPTH];
  logic [3:0][IN_WIDTH-1:0] r_mem_c1i [DEPTH];
  logic [3:0][IN_WIDTH-1:0] r_mem_c2r [DEPTH];
  logic [3:0][IN_WIDTH-1:0] r_mem_c2i [DEPTH];
  logic [10:0]              r_mem_idx1 [DEPTH];
  logic [10:0]              r_mem_idx2 [DEPTH];

  state_t                r_state, w_state_nxt;
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [2:0]            r_sub, w_sub_nxt;
  logic [LW-1:0]         r_level, w_level_nxt;
  logic                  r_af, r_ovf;
  logic [OUT_WIDTH-1:0]  r_out_r, r_out_i, w_re_cv, w_im_cv;
  logic [12:0]           r_out_addr;
  logic                  r_out_last;
  logic                  w_push, w_drop, w_xfer, w_pop, w_load, w_bypass, w_col2;
  logic [1:0]            w_lane;
  logic [IN_WIDTH-1:0]   w_re_sel, w_im_sel;
  logic [10:0]           w_idx_sel;

  // A full FIFO drops the incoming beat even if the head pops this cycle
  assign w_push      = in_valid && (r_level != FULL_LVL);
  assign w_drop      = in_valid && (r_level == FULL_LVL);
  assign w_xfer      = (r_state == S_STREAM) && out_ready;
  assign w_pop       = w_xfer && (r_sub == 3'd7);
  assign w_level_nxt = r_level + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
  assign w_sub_nxt   = w_xfer ? r_sub + 3'd1 : r_sub;
  assign w_rd_nxt    = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
  // The beat being written this edge becomes the head when only the popped beat was stored
  assign w_bypass    = w_push && (r_wr_ptr == w_rd_nxt);
  assign w_col2      = w_sub_nxt[2];
  assign w_lane      = w_sub_nxt[1:0];

  // Next FSM state and when to register a new sample onto the outputs
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0) begin
          w_state_nxt = S_STREAM;
          w_load      = 1'b1;
        end
      end
      S_STREAM: begin
        if (w_pop && (w_level_nxt == '0)) w_state_nxt = S_IDLE;
        else if (w_xfer)                  w_load      = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pick the next sample from the new head beat (or the incoming beat on bypass)
  always_comb begin
    w_re_sel  = '0;
    w_im_sel  = '0;
    w_idx_sel = '0;
    if (w_bypass) begin
      w_re_sel  = w_col2 ? in_col2_r[w_lane] : in_col1_r[w_lane];
      w_im_sel  = w_col2 ? in_col2_i[w_lane] : in_col1_i[w_lane];
      w_idx_sel = w_col2 ? in_idx_col2 : in_idx_col1;
    end else begin
      w_re_sel  = w_col2 ? r_mem_c2r[w_rd_nxt][w_lane] : r_mem_c1r[w_rd_nxt][w_lane];
      w_im_sel  = w_col2 ? r_mem_c2i[w_rd_nxt][w_lane] : r_mem_c1i[w_rd_nxt][w_lane];
      w_idx_sel = w_col2 ? r_mem_idx2[w_rd_nxt] : r_mem_idx1[w_rd_nxt];
    end
  end

`ifdef FFT_RESULT_SER_SAT_EN
  localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // Clamp when the bits above the output sign are not a pure sign extension
  always_comb begin
    w_re_cv = w_re_sel[OUT_WIDTH-1:0];
    w_im_cv = w_im_sel[OUT_WIDTH-1:0];
    if (!(&w_re_sel[IN_WIDTH-1:OUT_WIDTH-1]) && (|w_re_sel[IN_WIDTH-1:OUT_WIDTH-1]))
      w_re_cv = w_re_sel[IN_WIDTH-1] ? SAT_MIN : SAT_MAX;
    if (!(&w_im_sel[IN_WIDTH-1:OUT_WIDTH-1]) && (|w_im_sel[IN_WIDTH-1:OUT_WIDTH-1]))
      w_im_cv = w_im_sel[IN_WIDTH-1] ? SAT_MIN : SAT_MAX;
  end
`else
  assign w_re_cv = w_re_sel[OUT_WIDTH-1:0];
  assign w_im_cv = w_im_sel[OUT_WIDTH-1:0];
  if (IN_WIDTH > OUT_WIDTH) begin : g_trunc
    logic w_unused_hi;
    assign w_unused_hi = ^{w_re_sel[IN_WIDTH-1:OUT_WIDTH], w_im_sel[IN_WIDTH-1:OUT_WIDTH]};
  end
`endif

  // Beat storage, written at the write pointer on an accepted push
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_c1r[r_wr_ptr]  <= in_col1_r;
      r_mem_c1i[r_wr_ptr]  <= in_col1_i;
      r_mem_c2r[r_wr_ptr]  <= in_col2_r;
      r_mem_c2i[r_wr_ptr]  <= in_col2_i;
      r_mem_idx1[r_wr_ptr] <= in_idx_col1;
      r_mem_idx2[r_wr_ptr] <= in_idx_col2;
    end
  end

  // Control state, occupancy, flags and registered sample outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_sub      <= '0;
      r_level    <= '0;
      r_af       <= 1'b0;
      r_ovf      <= 1'b0;
      r_out_r    <= '0;
      r_out_i    <= '0;
      r_out_addr <= '0;
      r_out_last <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_sub    <= w_sub_nxt;
      r_level  <= w_level_nxt;
      r_af     <= (w_level_nxt >= AF_TH);
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
      if (w_load) begin
        r_out_r    <= w_re_cv;
        r_out_i    <= w_im_cv;
        r_out_addr <= {w_idx_sel, w_lane};
        r_out_last <= (w_sub_nxt == 3'd7);
      end
    end
  end

  assign out_valid   = (r_state == S_STREAM);
  assign out_r       = r_out_r;
  assign out_i       = r_out_i;
  assign out_addr    = r_out_addr;
  assign out_last    = r_out_last;
  assign almost_full = r_af;
  assign level       = r_level;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_fft_result_serializer.sv
// tb/tb_fft_result_serializer.sv - randomized scenario bench for fft_result_serializer against a queue model
module tb_fft_result_serializer;
  localparam int IW = 32;
  localparam int OW = 24;
  localparam int DEPTH = 8;
  localparam int AF_MARGIN = 7;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
  logic [3:0][IW-1:0] c1r = '0, c1i = '0, c2r = '0, c2i = '0;
  logic [10:0] idx1 = '0, idx2 = '0;
  logic out_valid, out_last, almost_full, overflow;
  logic [OW-1:0] out_r, out_i;
  logic [12:0] out_addr;
  logic [3:0] level;

  always #5 clk = ~clk;

  fft_result_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_col1_r(c1r), .in_col1_i(c1i), .in_col2_r(c2r), .in_col2_i(c2i),
    .in_idx_col1(idx1), .in_idx_col2(idx2),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
    .out_addr(out_addr), .out_last(out_last), .almost_full(almost_full),
    .level(level), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic [OW-1:0] r;
    logic [OW-1:0] i;
    logic [12:0]   a;
    logic          l;
  } samp_t;

  int errors = 0, checks = 0;
  samp_t exp_q[$];
  int m_level = 0, m_prev = 0;
  bit m_ovf = 0;

  // Reference conversion: numeric range test on the signed input value
  function automatic logic [OW-1:0] ref_conv(input logic [IW-1:0] v);
`ifdef FFT_RESULT_SER_SAT_EN
    longint s;
    s = longint'(signed'(v));
    if (s > (longint'(1) <<< (OW-1)) - 1) return {1'b0, {(OW-1){1'b1}}};
    if (s < -(longint'(1) <<< (OW-1)))    return {1'b1, {(OW-1){1'b0}}};
`endif
    return v[OW-1:0];
  endfunction

  function automatic logic [IW-1:0] rnd_val();
    logic [IW-1:0] x;
    x = $urandom;
    if ($urandom_range(1, 0) == 0) x = {{(IW-OW){x[OW-1]}}, x[OW-1:0]};
    return x;
  endfunction

  task automatic rand_beat();
    for (int l = 0; l < 4; l++) begin
      c1r[l] = rnd_val(); c1i[l] = rnd_val();
      c2r[l] = rnd_val(); c2i[l] = rnd_val();
    end
    idx1 = 11'($urandom);
    idx2 = 11'($urandom);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_level = 0;
    m_prev = 0;
    m_ovf = 0;
  endtask

  // Advance the model across the coming clock edge using the inputs now being driven
  task automatic model_edge();
    int pre;
    bit v;
    samp_t s;
    pre = m_level;
    v = (m_level > 0) && (m_prev > 0);
    if (v && out_ready && exp_q.size() > 0) begin
      if (exp_q[0].l) m_level--;
      void'(exp_q.pop_front());
    end
    m_prev = pre;
    if (in_valid && pre >= DEPTH) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    if (in_valid && pre < DEPTH) begin
      for (int k = 0; k < 8; k++) begin
        s.r = ref_conv(k < 4 ? c1r[k % 4] : c2r[k % 4]);
        s.i = ref_conv(k < 4 ? c1i[k % 4] : c2i[k % 4]);
        s.a = 13'((k < 4 ? idx1 : idx2) * 4 + k % 4);
        s.l = (k == 7);
        exp_q.push_back(s);
      end
      m_level++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if ({out_last, out_r, out_i, out_addr, almost_full, overflow} !== '0) begin
      errors++; $display("FAIL reset_outs got last=%b r=%h i=%h a=%h af=%b ovf=%b exp all 0", out_last, out_r, out_i, out_addr, almost_full, overflow);
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    int k = 0;
    bit ev;
    rand_beat();
    c1r = {32'd4, 32'd3, 32'd2, 32'd1};
    idx1 = 11'd5; idx2 = 11'd6;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1 in_valid = (c == 0); out_ready = 1'b1;
      @(negedge clk);
      ev = (m_level > 0) && (m_prev > 0);
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL single_valid c=%0d got=%b exp=%b", c, out_valid, ev); end
      checks++; if (level !== 4'(m_level)) begin errors++; $display("FAIL single_level c=%0d got=%0d exp=%0d", c, level, m_level); end
      if (ev && exp_q.size() > 0) begin
        checks++;
        if ({out_r, out_i, out_addr, out_last} !== {exp_q[0].r, exp_q[0].i, exp_q[0].a, exp_q[0].l}) begin
          errors++; $display("FAIL single_sample got r=%h i=%h a=%0d l=%b exp r=%h i=%h a=%0d l=%b", out_r, out_i, out_addr, out_last, exp_q[0].r, exp_q[0].i, exp_q[0].a, exp_q[0].l);
        end
      end
      if (out_valid) begin
        checks++;
        if (out_addr !== 13'(20 + k) || (k < 4 && out_r !== 24'(k + 1)) || out_last !== (k == 7) || (k == 0 && c != 2)) begin
          errors++; $display("FAIL single_fixed k=%0d c=%0d got a=%0d r=%0d l=%b exp a=%0d r=%0d first at c=2", k, c, out_addr, out_r, out_last, 20 + k, k + 1);
        end
        k++;
      end
      model_edge();
    end
    checks++; if (k !== 8) begin errors++; $display("FAIL single_count got=%0d exp=8", k); end
  endtask

  task automatic test_overflow();
    int cnt = 0;
    bit ev;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1 in_valid = (c < DEPTH + 2); ovf_clr = (c == DEPTH + 1); out_ready = 1'b0;
      if (in_valid) rand_beat();
      @(negedge clk);
      ev = (m_level > 0) && (m_prev > 0);
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL ovf_valid c=%0d got=%b exp=%b", c, out_valid, ev); end
      checks++; if (level !== 4'(m_level)) begin errors++; $display("FAIL ovf_level c=%0d got=%0d exp=%0d", c, level, m_level); end
      checks++; if (almost_full !== (m_level >= DEPTH - AF_MARGIN)) begin errors++; $display("FAIL ovf_af c=%0d got=%b level=%0d", c, almost_full, m_level); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_flag c=%0d got=%b exp=%b", c, overflow, m_ovf); end
      if (ev && exp_q.size() > 0) begin
        checks++;
        if ({out_r, out_i, out_addr, out_last} !== {exp_q[0].r, exp_q[0].i, exp_q[0].a, exp_q[0].l}) begin
          errors++; $display("FAIL ovf_hold got r=%h a=%0d exp r=%h a=%0d", out_r, out_addr, exp_q[0].r, exp_q[0].a);
        end
      end
      model_edge();
    end
    checks++; if ({level, almost_full, overflow} !== {4'd8, 1'b1, 1'b1}) begin
      errors++; $display("FAIL ovf_full got level=%0d af=%b ovf=%b exp 8 1 1", level, almost_full, overflow);
    end
    @(posedge clk); #1 in_valid = 1'b0; ovf_clr = 1'b1;
    @(negedge clk); model_edge();
    @(posedge clk); #1 ovf_clr = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    for (int c = 0; c < 80; c++) begin
      if (c > 0) begin @(posedge clk); #1; @(negedge clk); end
      ev = (m_level > 0) && (m_prev > 0);
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL drain_valid c=%0d got=%b exp=%b", c, out_valid, ev); end
      if (ev && exp_q.size() > 0) begin
        checks++;
        if ({out_r, out_i, out_addr, out_last} !== {exp_q[0].r, exp_q[0].i, exp_q[0].a, exp_q[0].l}) begin
          errors++; $display("FAIL drain_sample got r=%h i=%h a=%0d l=%b exp r=%h i=%h a=%0d l=%b", out_r, out_i, out_addr, out_last, exp_q[0].r, exp_q[0].i, exp_q[0].a, exp_q[0].l);
        end
      end
      if (out_valid) cnt++;
      model_edge();
    end
    checks++; if (cnt !== 64 || level !== 4'd0) begin errors++; $display("FAIL drain_count got=%0d level=%0d exp=64 level=0", cnt, level); end
  endtask

  task automatic test_back_to_back();
    int sent = 0, rx = 0;
    bit started = 0, ev;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1 out_ready = 1'b1;
      ev = (m_level > 0) && (m_prev > 0);
      in_valid = (sent < 5) && (sent == 0 || (ev && exp_q.size() > 0 && exp_q[0].l));
      if (in_valid) begin rand_beat(); sent++; end
      @(negedge clk);
      ev = (m_level > 0) && (m_prev > 0);
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, out_valid, ev); end
      if (ev && exp_q.size() > 0) begin
        checks++;
        if ({out_r, out_i, out_addr, out_last} !== {exp_q[0].r, exp_q[0].i, exp_q[0].a, exp_q[0].l}) begin
          errors++; $display("FAIL b2b_sample got r=%h i=%h a=%0d l=%b exp r=%h i=%h a=%0d l=%b", out_r, out_i, out_addr, out_last, exp_q[0].r, exp_q[0].i, exp_q[0].a, exp_q[0].l);
        end
      end
      if (started && rx < 40) begin
        checks++; if (out_valid !== 1'b1 || level !== 4'd1) begin errors++; $display("FAIL b2b_bubble c=%0d got valid=%b level=%0d exp 1 1", c, out_valid, level); end
      end
      if (out_valid) begin started = 1; rx++; end
      model_edge();
    end
    in_valid = 1'b0;
    checks++; if (rx !== 40) begin errors++; $display("FAIL b2b_count got=%0d exp=40", rx); end
  endtask

  task automatic test_stall();
    int rx = 0;
    bit ev, pv = 0, pr = 0;
    logic [OW*2+13:0] prev_out = '0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1 in_valid = (c < 3); out_ready = (c % 2 == 1);
      if (in_valid) rand_beat();
      @(negedge clk);
      ev = (m_level > 0) && (m_prev > 0);
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL stall_valid c=%0d got=%b exp=%b", c, out_valid, ev); end
      if (ev && exp_q.size() > 0) begin
        checks++;
        if ({out_r, out_i, out_addr, out_last} !== {exp_q[0].r, exp_q[0].i, exp_q[0].a, exp_q[0].l}) begin
          errors++; $display("FAIL stall_sample got r=%h i=%h a=%0d l=%b exp r=%h i=%h a=%0d l=%b", out_r, out_i, out_addr, out_last, exp_q[0].r, exp_q[0].i, exp_q[0].a, exp_q[0].l);
        end
      end
      if (pv && !pr) begin
        checks++; if ({out_valid, out_r, out_i, out_addr, out_last} !== {1'b1, prev_out}) begin
          errors++; $display("FAIL stall_stable c=%0d got=%h exp=%h", c, {out_r, out_i, out_addr, out_last}, prev_out);
        end
      end
      pv = out_valid; pr = out_ready;
      prev_out = {out_r, out_i, out_addr, out_last};
      if (out_valid && out_ready) rx++;
      model_edge();
    end
    checks++; if (rx !== 24) begin errors++; $display("FAIL stall_count got=%0d exp=24", rx); end
  endtask

  task automatic test_conversion();
    int k = 0;
    bit ev;
    logic [OW-1:0] cv [4];
`ifdef FFT_RESULT_SER_SAT_EN
    cv = '{24'h7F_FFFF, 24'h80_0000, 24'h80_0000, 24'h7F_FFFF};
`else
    cv = '{24'h00_0000, 24'h00_0000, 24'h80_0000, 24'h7F_FFFF};
`endif
    rand_beat();
    c1r = {32'h007F_FFFF, 32'hFF80_0000, 32'hFF00_0000, 32'h0100_0000};
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1 in_valid = (c == 0); out_ready = 1'b1;
      @(negedge clk);
      ev = (m_level > 0) && (m_prev > 0);
      if (ev && exp_q.size() > 0) begin
        checks++;
        if ({out_r, out_i, out_addr, out_last} !== {exp_q[0].r, exp_q[0].i, exp_q[0].a, exp_q[0].l}) begin
          errors++; $display("FAIL conv_sample got r=%h i=%h a=%0d exp r=%h i=%h a=%0d", out_r, out_i, out_addr, exp_q[0].r, exp_q[0].i, exp_q[0].a);
        end
      end
      if (out_valid && k < 4) begin
        checks++; if (out_r !== cv[k]) begin errors++; $display("FAIL conv_fixed lane=%0d got=%h exp=%h", k, out_r, cv[k]); end
        k++;
      end
      model_edge();
    end
    checks++; if (k !== 4) begin errors++; $display("FAIL conv_count got=%0d exp=4", k); end
  endtask

  task automatic test_reset_midstream();
    bit found = 0;
    for (int c = 0; c < DEPTH + 1; c++) begin
      @(posedge clk); #1 in_valid = 1'b1; out_ready = 1'b0; rand_beat();
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (out_valid && out_addr[1:0] == 2'd3) found = 1;
      else @(posedge clk);
    end
    checks++; if (!found || overflow !== 1'b1) begin errors++; $display("FAIL mid_setup got found=%b ovf=%b exp 1 1", found, overflow); end
    rst = 1'b1;
    #1;
    checks++; if ({out_valid, level, overflow, almost_full} !== '0) begin
      errors++; $display("FAIL mid_reset got valid=%b level=%0d ovf=%b af=%b exp all 0", out_valid, level, overflow, almost_full);
    end
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL mid_after c=%0d got valid=%b level=%0d exp 0 0", c, out_valid, level); end
      @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_conversion();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
